// File: rtl/instr_issuer_if.sv
// Command/handshake bundle between the host, the instruction issuer and the datapath control unit.
// The slave modport is the issuer's view; master is the host/harness side.
interface instr_issuer_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4,
    parameter int FUNC_W  = 3
);
    localparam int INSTR_W = FUNC_W + 2 * RADDR_W + DATA_W;

    logic               load_valid;
    logic [INSTR_W-1:0] load_instr;
    logic               load_ready;
    logic               start;
    logic               clear;
    logic               done;
    logic               w;
    logic [FUNC_W-1:0]  func;
    logic [RADDR_W-1:0] rx;
    logic [RADDR_W-1:0] ry;
    logic [DATA_W-1:0]  data;
    logic               busy;
    logic               halted;
    logic               err;
    logic [7:0]         issued_cnt;

    modport slave (
        input  load_valid, load_instr, start, clear, done,
        output load_ready, w, func, rx, ry, data, busy, halted, err, issued_cnt
    );

    modport master (
        output load_valid, load_instr, start, clear, done,
        input  load_ready, w, func, rx, ry, data, busy, halted, err, issued_cnt
    );
endinterface

// File: rtl/instr_issuer.sv
// Instruction sequencer: buffers host words in a circular queue and issues them one per
// datapath handshake (w strobe out, done back), with a done timeout that latches an error.
module instr_issuer #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4,
    parameter int FUNC_W  = 3,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    instr_issuer_if.slave  bus
);
    localparam int INSTR_W = FUNC_W + 2 * RADDR_W + DATA_W;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int TMR_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    logic [1:0]         state;
    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [TMR_W-1:0]   timer;
    logic [INSTR_W-1:0] head;
    logic               head_halt;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign head      = mem[rd_ptr];
    assign head_halt = (head[INSTR_W-1 -: FUNC_W] == {FUNC_W{1'b1}});
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

    // The queue is frozen in ERROR, so the host sees no room there either.
    assign bus.load_ready = !full && (state != S_ERROR);
    assign push           = bus.load_valid && bus.load_ready && !bus.clear;
    assign pop            = (state == S_ISSUE) && !bus.clear;

    assign bus.busy   = (state == S_ISSUE) || (state == S_WAIT);
    assign bus.halted = pop && head_halt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.load_instr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            bus.w          <= 1'b0;
            bus.func       <= '0;
            bus.rx         <= '0;
            bus.ry         <= '0;
            bus.data       <= '0;
            bus.err        <= 1'b0;
            bus.issued_cnt <= '0;
            timer          <= '0;
        end else begin
            bus.w <= 1'b0;
            if (bus.clear) begin
                state   <= S_IDLE;
                bus.err <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start && !empty) state <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        if (head_halt) begin
                            state <= S_IDLE;
                        end else begin
                            {bus.func, bus.rx, bus.ry, bus.data} <= head;
                            bus.w          <= 1'b1;
                            bus.issued_cnt <= bus.issued_cnt + 1'b1;
                            timer          <= '0;
                            state          <= S_WAIT;
                        end
                    end
                    // done is checked before the limit so a reply on the last cycle still counts.
                    S_WAIT: begin
                        if (bus.done) begin
                            state <= empty ? S_IDLE : S_ISSUE;
                        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                            state   <= S_ERROR;
                            bus.err <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    S_ERROR: state <= S_ERROR;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: directed scenarios plus randomized word streams
// compared against a queue-based model of the issue order.
module tb_instr_issuer;
    localparam int DATA_W  = 32;
    localparam int RADDR_W = 4;
    localparam int FUNC_W  = 3;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int IW      = FUNC_W + 2 * RADDR_W + DATA_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    instr_issuer_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .FUNC_W(FUNC_W)) bus ();

    instr_issuer #(
        .DATA_W(DATA_W), .RADDR_W(RADDR_W), .FUNC_W(FUNC_W),
        .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int              vectors    = 0;
    int              miscompares = 0;
    logic [7:0]      exp_cnt    = 8'd0;
    logic [IW-1:0]   model_q[$];

    function automatic logic [IW-1:0] mk(input logic [2:0] f, input logic [3:0] x,
                                         input logic [3:0] y, input logic [31:0] d);
        return {f, x, y, d};
    endfunction

    function automatic logic [IW-1:0] rand_word(input bit allow_halt);
        logic [FUNC_W-1:0] f;
        f = FUNC_W'($urandom_range(0, 6));
        if (allow_halt && $urandom_range(0, 4) == 0) f = '1;
        return {f, RADDR_W'($urandom), RADDR_W'($urandom), DATA_W'($urandom)};
    endfunction

    function automatic logic [IW-1:0] fields();
        return {bus.func, bus.rx, bus.ry, bus.data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [IW-1:0] word);
        bus.load_valid = 1'b1;
        bus.load_instr = word;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_done();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
    endtask

    task automatic wait_w(output int waited);
        waited = 0;
        while (bus.w !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
    endtask

    // Plays the datapath for every word in model_q, in order; HALT words need a fresh start.
    task automatic drain_model(input string tag);
        logic [IW-1:0] exp;
        int waited;
        int d;
        while (model_q.size() > 0) begin
            exp = model_q.pop_front();
            waited = 0;
            while (bus.w !== 1'b1 && bus.halted !== 1'b1 && waited < 20) begin
                tick();
                waited++;
            end
            if (exp[IW-1 -: FUNC_W] == {FUNC_W{1'b1}}) begin
                vectors++;
                if (bus.halted !== 1'b1 || bus.w !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL %s halt pulse: halted=%b w=%b, required halted=1 w=0",
                             tag, bus.halted, bus.w);
                end
                tick();
                vectors++;
                if (bus.busy !== 1'b0 || bus.halted !== 1'b0 || bus.w !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL %s after halt: busy=%b halted=%b w=%b, required all 0",
                             tag, bus.busy, bus.halted, bus.w);
                end
                if (model_q.size() > 0) pulse_start();
            end else begin
                exp_cnt++;
                vectors++;
                if (bus.w !== 1'b1 || fields() !== exp || bus.issued_cnt !== exp_cnt) begin
                    miscompares++;
                    $display("[TB] FAIL %s issue: w=%b word=%h cnt=%0d, required w=1 word=%h cnt=%0d",
                             tag, bus.w, fields(), bus.issued_cnt, exp, exp_cnt);
                end
                d = $urandom_range(0, 3);
                repeat (d) tick();
                pulse_done();
            end
        end
        tick();
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL %s final busy: got %b, required 0", tag, bus.busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.w, bus.func, bus.rx, bus.ry, bus.data, bus.busy, bus.halted, bus.err,
             bus.issued_cnt} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset outputs: w=%b word=%h busy=%b halted=%b err=%b cnt=%0d, required all 0",
                     bus.w, fields(), bus.busy, bus.halted, bus.err, bus.issued_cnt);
        end
        vectors++;
        if (bus.load_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset load_ready: got %b, required 1", bus.load_ready);
        end
        @(negedge clk);
        reset   = 1'b1;
        exp_cnt = 8'd0;
        tick();
    endtask

    task automatic test_basic();
        logic [IW-1:0] words [3];
        int waited;
        words[0] = mk(3'd0, 4'd1, 4'd0, 32'd5);
        words[1] = mk(3'd1, 4'd2, 4'd3, 32'h0000_1234);
        words[2] = mk(3'd2, 4'd7, 4'd9, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) load_word(words[i]);
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            wait_w(waited);
            exp_cnt++;
            vectors++;
            if (waited !== 1) begin
                miscompares++;
                $display("[TB] FAIL basic latency %0d: got %0d cycles, required 1", k, waited);
            end
            vectors++;
            if (fields() !== words[k] || bus.issued_cnt !== exp_cnt) begin
                miscompares++;
                $display("[TB] FAIL basic issue %0d: word=%h cnt=%0d, required word=%h cnt=%0d",
                         k, fields(), bus.issued_cnt, words[k], exp_cnt);
            end
            for (int c = 0; c < 3; c++) begin
                tick();
                vectors++;
                if (bus.w !== 1'b0 || fields() !== words[k]) begin
                    miscompares++;
                    $display("[TB] FAIL basic hold %0d: w=%b word=%h, required w=0 word=%h",
                             k, bus.w, fields(), words[k]);
                end
            end
            pulse_done();
        end
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.issued_cnt !== 8'd3) begin
            miscompares++;
            $display("[TB] FAIL basic end: busy=%b cnt=%0d, required busy=0 cnt=3",
                     bus.busy, bus.issued_cnt);
        end
    endtask

    task automatic test_full();
        logic [IW-1:0] word;
        logic [IW-1:0] exp;
        int waited;
        for (int i = 0; i < DEPTH + 2; i++) begin
            word = rand_word(1'b0);
            bus.load_valid = 1'b1;
            bus.load_instr = word;
            vectors++;
            if (bus.load_ready !== (i < DEPTH)) begin
                miscompares++;
                $display("[TB] FAIL full load_ready at word %0d: got %b, required %b",
                         i, bus.load_ready, (i < DEPTH));
            end
            if (i < DEPTH) model_q.push_back(word);
            tick();
        end
        bus.load_valid = 1'b0;
        pulse_start();
        wait_w(waited);
        exp = model_q.pop_front();
        exp_cnt++;
        vectors++;
        if (fields() !== exp || bus.w !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full first issue: w=%b word=%h, required w=1 word=%h",
                     bus.w, fields(), exp);
        end
        word = rand_word(1'b0);
        bus.load_valid = 1'b1;
        bus.load_instr = word;
        vectors++;
        if (bus.load_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full reopen: load_ready=%b, required 1", bus.load_ready);
        end
        model_q.push_back(word);
        tick();
        bus.load_instr = rand_word(1'b0);
        vectors++;
        if (bus.load_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full refill: load_ready=%b, required 0", bus.load_ready);
        end
        tick();
        bus.load_valid = 1'b0;
        pulse_done();
        drain_model("full");
    endtask

    task automatic test_halt();
        model_q.push_back(mk(3'd0, 4'd1, 4'd2, 32'd100));
        model_q.push_back(mk(3'd7, 4'd0, 4'd0, 32'd0));
        model_q.push_back(mk(3'd3, 4'd4, 4'd5, 32'd200));
        foreach (model_q[i]) load_word(model_q[i]);
        pulse_start();
        drain_model("halt");
    endtask

    task automatic test_timeout();
        int waited;
        load_word(rand_word(1'b0));
        load_word(rand_word(1'b0));
        pulse_start();
        wait_w(waited);
        exp_cnt++;
        vectors++;
        if (bus.w !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout issue: w=%b, required 1", bus.w);
        end
        repeat (TIMEOUT - 1) tick();
        vectors++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout early: err=%b busy=%b, required err=0 busy=1",
                     bus.err, bus.busy);
        end
        tick();
        vectors++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.load_ready !== 1'b0 || bus.w !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout error: err=%b busy=%b ready=%b w=%b, required 1 0 0 0",
                     bus.err, bus.busy, bus.load_ready, bus.w);
        end
        bus.load_valid = 1'b1;
        bus.load_instr = rand_word(1'b0);
        bus.done  = 1'b1;
        bus.start = 1'b1;
        repeat (3) tick();
        bus.load_valid = 1'b0;
        bus.done  = 1'b0;
        bus.start = 1'b0;
        vectors++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.w !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout sticky: err=%b busy=%b w=%b, required 1 0 0",
                     bus.err, bus.busy, bus.w);
        end
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        vectors++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.load_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout clear: err=%b busy=%b ready=%b, required 0 0 1",
                     bus.err, bus.busy, bus.load_ready);
        end
        pulse_start();
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.w !== 1'b0 || bus.issued_cnt !== exp_cnt) begin
            miscompares++;
            $display("[TB] FAIL timeout empty after clear: busy=%b w=%b cnt=%0d, required 0 0 %0d",
                     bus.busy, bus.w, bus.issued_cnt, exp_cnt);
        end
    endtask

    task automatic test_done_at_limit();
        logic [IW-1:0] w1;
        logic [IW-1:0] w2;
        int waited;
        w1 = rand_word(1'b0);
        w2 = rand_word(1'b0);
        load_word(w1);
        load_word(w2);
        pulse_start();
        wait_w(waited);
        exp_cnt++;
        repeat (TIMEOUT - 1) tick();
        pulse_done();
        vectors++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL limit done: err=%b busy=%b, required err=0 busy=1",
                     bus.err, bus.busy);
        end
        wait_w(waited);
        exp_cnt++;
        vectors++;
        if (fields() !== w2 || waited !== 1 || bus.issued_cnt !== exp_cnt) begin
            miscompares++;
            $display("[TB] FAIL limit next issue: word=%h wait=%0d cnt=%0d, required word=%h wait=1 cnt=%0d",
                     fields(), waited, bus.issued_cnt, w2, exp_cnt);
        end
        pulse_done();
        vectors++;
        if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL limit end: busy=%b err=%b, required 0 0", bus.busy, bus.err);
        end
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) model_q.push_back(rand_word(1'b1));
            foreach (model_q[i]) load_word(model_q[i]);
            pulse_start();
            drain_model("random");
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        for (int i = 0; i < 5; i++) load_word(rand_word(1'b0));
        pulse_start();
        wait_w(waited);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({bus.w, bus.func, bus.rx, bus.ry, bus.data, bus.busy, bus.halted, bus.err,
             bus.issued_cnt} !== '0) begin
            miscompares++;
            $display("[TB] FAIL async reset: w=%b word=%h busy=%b err=%b cnt=%0d, required all 0",
                     bus.w, fields(), bus.busy, bus.err, bus.issued_cnt);
        end
        exp_cnt = 8'd0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        pulse_start();
        tick();
        tick();
        vectors++;
        if (bus.w !== 1'b0 || bus.busy !== 1'b0 || bus.issued_cnt !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL reset queue lost: w=%b busy=%b cnt=%0d, required 0 0 0",
                     bus.w, bus.busy, bus.issued_cnt);
        end
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.load_instr = '0;
        bus.start      = 1'b0;
        bus.clear      = 1'b0;
        bus.done       = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_full();
        test_halt();
        test_timeout();
        test_done_at_limit();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
